uart_tx: RTL

- Serial UART transmitter that consumes the byte writes the bus decodes into the UART address window.
- Buffers bytes in a small FIFO and drives an 8N1 serial line, so the single-cycle CPU never waits on the wire.
- Sits directly downstream of the bus uart_* port group; replaces the write-and-forget sink with real line timing.
- The bus has no ready/stall path, so overflow is reported through error and the byte is dropped.

---
 rtl/uart_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter fed from a small TX FIFO.
// Optional macro UART_TX_SIM_PRINT_EN echoes each accepted byte to the simulator console.
module uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cen,
  input  logic                          wr,
  input  logic [7:0]                    wdata,
  output logic                          error,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0]   BAUD_LAST  = 16'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [LW-1:0] level_d;
  logic          full, push, pop, txd_d, busy_d, baud_end;

  // Fullness is judged on the level at the start of the cycle, so a pop in
  // the same cycle never makes room for a push.
  assign full     = (fifo_level == FULL_LEVEL);
  assign push     = cen && wr && !full;
  assign error    = cen && (!wr || full);
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fifo_level != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value follows the state being entered so txd switches on that edge.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    level_d = fifo_level + LW'(push) - LW'(pop);
    busy_d  = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      fifo_level <= level_d;
      txd        <= txd_d;
      tx_busy    <= busy_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

`ifdef UART_TX_SIM_PRINT_EN
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      $write("%c", wdata);
    end
  end
`endif

endmodule
